// File: rtl/logic_op_pkg.sv
// Shared types and the per-bit operator for the logic_op_pipe datapath.
package logic_op_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic {
    SLICE_EMPTY = 1'b0,
    SLICE_FULL  = 1'b1
  } slice_state_e;

  // Single-bit operator; callers apply it across the operand width so the
  // function stays independent of WIDTH.
  function automatic logic op_apply(input op_e op, input logic a, input logic b);
    logic r;
    case (op)
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_op_slice.sv
// Valid/ready register slice with an EMPTY/FULL state machine and a
// parametrised payload. Accepts while empty or while the held item leaves.
module logic_op_slice
  import logic_op_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  slice_state_e state_q, state_n;
  logic [W-1:0] data_q;
  logic         load;
  logic         unload;

  assign load   = in_valid && in_ready;
  assign unload = out_valid && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= SLICE_EMPTY;
    else     state_q <= state_n;
  end

  // Next state: fill on load, drain on unload unless refilled in the same cycle
  always_comb begin
    state_n = state_q;
    case (state_q)
      SLICE_EMPTY: if (load)            state_n = SLICE_FULL;
      SLICE_FULL:  if (unload && !load) state_n = SLICE_EMPTY;
      default:                          state_n = SLICE_EMPTY;
    endcase
  end

  // Handshake outputs derived from the current state
  always_comb begin
    out_valid = (state_q == SLICE_FULL);
    in_ready  = (state_q == SLICE_EMPTY) || out_ready;
  end

  // Payload register, written only on an accepted transfer
  always_ff @(posedge clk) begin
    if (rst)       data_q <= '0;
    else if (load) data_q <= in_data;
  end

  assign out_data = data_q;

endmodule

// File: rtl/logic_op_pipe.sv
// Two-stage pipelined bitwise logic unit (OR/AND/XOR/NOR) with valid/ready
// on both sides. Optional completed-transfer counter: LOGIC_OP_PIPE_CNT_EN.
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  op_e              op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             C_any,
  output logic [CNT_W-1:0] ops_done
);

  localparam int unsigned S1_W = 2 + 2 * WIDTH;
  localparam int unsigned S2_W = 1 + WIDTH;

  logic [S1_W-1:0]  s1_data;
  logic             s1_valid;
  logic             s2_ready;
  logic [S2_W-1:0]  s2_data;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] c_calc;

  logic_op_slice #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({op, A, B}),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_data)
  );

  assign s1_op = op_e'(s1_data[2*WIDTH +: 2]);
  assign s1_a  = s1_data[WIDTH +: WIDTH];
  assign s1_b  = s1_data[0 +: WIDTH];

  // Apply the selected operator bit by bit to the captured operands
  always_comb begin
    c_calc = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      c_calc[i] = op_apply(s1_op, s1_a[i], s1_b[i]);
    end
  end

  logic_op_slice #(.W(S2_W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   ({|c_calc, c_calc}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign C     = s2_data[WIDTH-1:0];
  assign C_any = s2_data[WIDTH];

`ifdef LOGIC_OP_PIPE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Count completed output transfers, wrapping naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst)                         cnt_q <= '0;
    else if (out_valid && out_ready) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign ops_done = cnt_q;
`else
  assign ops_done = '0;
`endif

endmodule

// File: tb/tb_logic_op_pipe.sv
// Self-checking bench for logic_op_pipe: directed vector table plus
// handshake sequences, checked against a queue of expected results.
module tb_logic_op_pipe;
  import logic_op_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] A, B;
  op_e        op;
  logic       out_ready;

  logic        in_ready, out_valid, C_any;
  logic [7:0]  C;
  logic [15:0] ops_done;
  logic        in_ready4, out_valid4, C_any4;
  logic [7:0]  C4;
  logic [3:0]  ops_done4;

  int compares = 0;
  int errors   = 0;
  int n_done   = 0;

  typedef struct { logic [7:0] c; logic any; } res_t;
  res_t q[$];

  typedef struct { op_e op; logic [7:0] a; logic [7:0] b; logic [7:0] c; logic any; } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  logic_op_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .C(C), .C_any(C_any), .ops_done(ops_done)
  );

  logic_op_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .A(A), .B(B), .op(op), .out_valid(out_valid4), .out_ready(out_ready),
    .C(C4), .C_any(C_any4), .ops_done(ops_done4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compares++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic res_t model(input op_e o, input logic [7:0] a, input logic [7:0] b);
    res_t r;
    case (o)
      OP_OR:   r.c = a | b;
      OP_AND:  r.c = a & b;
      OP_XOR:  r.c = a ^ b;
      default: r.c = ~(a | b);
    endcase
    r.any = (r.c != 8'h00);
    return r;
  endfunction

  function automatic logic [31:0] exp_cnt(input int n, input int w);
`ifdef LOGIC_OP_PIPE_CNT_EN
    return 32'(n % (1 << w));
`else
    return 32'(0 * n * w);
`endif
  endfunction

  // One clock: check handshakes before the edge, update the scoreboard,
  // then check the counters just after the edge.
  task automatic tick();
    res_t e;
    #1;
    if (!rst) begin
      chk("in_ready", in_ready, (q.size() < 2) || out_ready);
      chk("in_ready4", in_ready4, (q.size() < 2) || out_ready);
      if (q.size() == 0) chk("idle_out_valid", out_valid, 0);
      else if (out_valid && out_ready) begin
        e = q.pop_front();
        chk("C", C, e.c);
        chk("C_any", C_any, e.any);
        chk("out_valid4", out_valid4, 1);
        chk("C4", C4, e.c);
        n_done++;
      end
      if (in_valid && in_ready) q.push_back(model(op, A, B));
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      n_done = 0;
    end
    #1;
    chk("ops_done", ops_done, exp_cnt(n_done, 16));
    chk("ops_done4", ops_done4, exp_cnt(n_done, 4));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive(input op_e o, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    op = o;
    A = a;
    B = b;
  endtask

  res_t hold;

  initial begin
    vecs[0] = '{OP_OR,  8'hF0, 8'h3C, 8'hFC, 1'b1};
    vecs[1] = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b1};
    vecs[2] = '{OP_XOR, 8'hF0, 8'h3C, 8'hCC, 1'b1};
    vecs[3] = '{OP_NOR, 8'hF0, 8'h3C, 8'h03, 1'b1};
    vecs[4] = '{OP_OR,  8'h00, 8'h00, 8'h00, 1'b0};
    vecs[5] = '{OP_AND, 8'hFF, 8'hFF, 8'hFF, 1'b1};
    vecs[6] = '{OP_XOR, 8'hAA, 8'hAA, 8'h00, 1'b0};
    vecs[7] = '{OP_NOR, 8'h00, 8'h00, 8'hFF, 1'b1};
    vecs[8] = '{OP_NOR, 8'hFF, 8'h00, 8'h00, 1'b0};
    vecs[9] = '{OP_AND, 8'h81, 8'h01, 8'h01, 1'b1};

    // Reset held for two cycles with in_valid asserted
    rst = 1'b1;
    out_ready = 1'b1;
    drive(OP_OR, 8'h55, 8'hAA);
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_C", C, 0);
    chk("rst_C_any", C_any, 0);
    chk("rst_ops_done", ops_done, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    tick();

    // Directed vectors: result appears on the second edge after acceptance
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      tick();
      in_valid = 1'b0;
      chk("lat_early", out_valid, 0);
      tick();
      chk("vec_out_valid", out_valid, 1);
      chk("vec_C", C, vecs[i].c);
      chk("vec_C_any", C_any, vecs[i].any);
      tick();
    end

    // Streaming: 16 back-to-back inputs, results on consecutive cycles
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i >= 2) chk("stream_no_bubble", out_valid, 1);
      if (i < 16) drive(op_e'(i[1:0]), 8'(i * 29 + 3), 8'(i * 7) ^ 8'h5A);
      else        in_valid = 1'b0;
      tick();
    end
    chk("stream_ov_end", out_valid, 0);
    chk("stream_count", ops_done, exp_cnt(16, 16));
    chk("stream_drained", q.size(), 0);

    // Backpressure: stall after the first result, then drain
    do_reset();
    out_ready = 1'b1;
    drive(OP_OR, 8'h12, 8'h40);
    tick();
    drive(OP_XOR, 8'hF5, 8'h0F);
    tick();
    hold = model(OP_OR, 8'h12, 8'h40);
    chk("bp_first_valid", out_valid, 1);
    chk("bp_first_C", C, hold.c);
    out_ready = 1'b0;
    drive(OP_AND, 8'h3C, 8'hE7);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_C", C, hold.c);
    end
    out_ready = 1'b1;
    tick();
    drive(OP_NOR, 8'h0C, 8'h30);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("bp_drained", q.size(), 0);
    chk("bp_count", ops_done, exp_cnt(4, 16));

    // Reset with both slices full: old items must never appear
    do_reset();
    out_ready = 1'b0;
    drive(OP_OR, 8'h01, 8'h02);
    tick();
    drive(OP_AND, 8'hFF, 8'h0F);
    tick();
    tick();
    chk("mid_full_valid", out_valid, 1);
    chk("mid_full_in_ready", in_ready, 0);
    out_ready = 1'b1;
    rst = 1'b1;
    tick();
    chk("mid_rst_out_valid", out_valid, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    drive(OP_XOR, 8'h77, 8'h70);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("mid_drained", q.size(), 0);

    // Counter wrap on the CNT_W=4 instance: 17 transfers
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      if (i < 17) drive(op_e'(i[1:0]), 8'(i), 8'(255 - i));
      else        in_valid = 1'b0;
      tick();
      if (n_done == 15) chk("wrap_15", ops_done4, exp_cnt(15, 4));
      if (n_done == 16) chk("wrap_0", ops_done4, exp_cnt(16, 4));
    end
    chk("wrap_1", ops_done4, exp_cnt(17, 4));
    chk("wrap_wide", ops_done, exp_cnt(17, 16));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
